// File: rtl/boreal_bus_xbar_pkg.sv
// Shared types and constants for the Boreal shared-bus interconnect.
package boreal_bus_xbar_pkg;

   localparam int unsigned BOREAL_BUS_AW = 32;
   localparam int unsigned BOREAL_BUS_DW = 32;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      XBAR_IDLE  = 2'd0,
      XBAR_ISSUE = 2'd1,
      XBAR_WAIT  = 2'd2,
      XBAR_RESP  = 2'd3
   } xbar_state_t;

   // Default SoC address map, used to build SLV_BASE/SLV_MASK at instantiation
   localparam logic [31:0] BOREAL_SRAM_BASE   = 32'h0000_0000;
   localparam logic [31:0] BOREAL_SRAM_MASK   = 32'hFFF0_0000;
   localparam logic [31:0] BOREAL_DMA_BASE    = 32'h4000_0000;
   localparam logic [31:0] BOREAL_DMA_MASK    = 32'hFFFF_F000;
   localparam logic [31:0] BOREAL_VEC_BASE    = 32'h4000_1000;
   localparam logic [31:0] BOREAL_VEC_MASK    = 32'hFFFF_F000;
   localparam logic [31:0] BOREAL_MBOX_BASE   = 32'h4000_2000;
   localparam logic [31:0] BOREAL_MBOX_MASK   = 32'hFFFF_F000;
   localparam logic [31:0] BOREAL_VM_BASE     = 32'h4001_0000;
   localparam logic [31:0] BOREAL_VM_MASK     = 32'hFFFF_0000;
   localparam logic [31:0] BOREAL_GATE_BASE   = 32'h4002_0000;
   localparam logic [31:0] BOREAL_GATE_MASK   = 32'hFFFF_F000;
   localparam logic [31:0] BOREAL_LEDGER_BASE = 32'h4003_0000;
   localparam logic [31:0] BOREAL_LEDGER_MASK = 32'hFFFF_0000;

   // 16-bit counter increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/boreal_bus_xbar_if.sv
// Bus bundle between the masters, the interconnect and the slaves.
// 'master' is the environment view (masters drive requests, slaves drive
// responses); 'slave' is the interconnect view.
interface boreal_bus_xbar_if
   import boreal_bus_xbar_pkg::*;
#(
   parameter int unsigned N_MST = 2,
   parameter int unsigned N_SLV = 4
);

   logic [N_MST-1:0]               m_req_valid;
   logic [N_MST-1:0]               m_req_ready;
   logic [N_MST-1:0]               m_req_we;
   logic [N_MST*BOREAL_BUS_AW-1:0] m_req_addr;
   logic [N_MST*BOREAL_BUS_DW-1:0] m_req_wdata;
   logic [N_MST*4-1:0]             m_req_wstrb;
   logic [N_MST-1:0]               m_resp_valid;
   logic [BOREAL_BUS_DW-1:0]       m_resp_rdata;
   logic                           m_resp_err;

   logic [N_SLV-1:0]               s_req_valid;
   logic                           s_req_we;
   logic [BOREAL_BUS_AW-1:0]       s_req_addr;
   logic [BOREAL_BUS_DW-1:0]       s_req_wdata;
   logic [3:0]                     s_req_wstrb;
   logic [N_SLV-1:0]               s_resp_valid;
   logic [N_SLV*BOREAL_BUS_DW-1:0] s_resp_rdata;
   logic [N_SLV-1:0]               s_resp_err;

   modport master (
      output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb,
      input  m_req_ready, m_resp_valid, m_resp_rdata, m_resp_err,
      input  s_req_valid, s_req_we, s_req_addr, s_req_wdata, s_req_wstrb,
      output s_resp_valid, s_resp_rdata, s_resp_err
   );

   modport slave (
      input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb,
      output m_req_ready, m_resp_valid, m_resp_rdata, m_resp_err,
      output s_req_valid, s_req_we, s_req_addr, s_req_wdata, s_req_wstrb,
      input  s_resp_valid, s_resp_rdata, s_resp_err
   );

endinterface

// File: rtl/boreal_bus_xbar_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after 'last' and wraps.
module boreal_rr_arbiter #(
   parameter int unsigned N = 2,
   localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [LW-1:0] idx,
   output logic          any
);

   // First requester found walking from last+1 modulo N
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!any && req[j] && (j == ((32'(last) + 32'd1 + k) % N))) begin
               any      = 1'b1;
               grant[j] = 1'b1;
               idx      = LW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/boreal_bus_xbar.sv
// N-master / M-slave shared-bus interconnect, one transaction in flight.
module boreal_bus_xbar
   import boreal_bus_xbar_pkg::*;
#(
   parameter int unsigned           N_MST    = 2,
   parameter int unsigned           N_SLV    = 4,
   parameter logic [N_SLV*32-1:0]   SLV_BASE = {N_SLV{32'h0}},
   parameter logic [N_SLV*32-1:0]   SLV_MASK = {N_SLV{32'hFFFF_0000}},
   parameter int unsigned           TIMEOUT  = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   boreal_bus_xbar_if.slave     bus,
   output logic                 busy,
   output logic [15:0]          decerr_cnt,
   output logic [15:0]          tmo_cnt
);

   localparam int unsigned MW = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

   xbar_state_t state_q, state_d;
   logic [MW-1:0] last_q, last_d;
   logic [MW-1:0] owner_q, owner_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [15:0]   timer_q, timer_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [15:0]   decerr_q, decerr_d;
   logic [15:0]   tmo_q, tmo_d;

   logic [N_MST-1:0] arb_grant;
   logic [MW-1:0]    arb_idx;
   logic             arb_any;

   logic          win_we;
   logic [31:0]   win_addr;
   logic [31:0]   win_wdata;
   logic [3:0]    win_wstrb;

   logic          dec_hit;
   logic [SW-1:0] dec_sel;
   logic          sel_rvalid;
   logic [31:0]   sel_rdata;
   logic          sel_rerr;

   boreal_rr_arbiter #(.N(N_MST)) u_arb (
      .req   (bus.m_req_valid),
      .last  (last_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Request fields of the arbitration winner
   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      win_wstrb = '0;
      for (int unsigned i = 0; i < N_MST; i++) begin
         if (arb_grant[i]) begin
            win_we    = bus.m_req_we[i];
            win_addr  = bus.m_req_addr[32*i +: 32];
            win_wdata = bus.m_req_wdata[32*i +: 32];
            win_wstrb = bus.m_req_wstrb[4*i +: 4];
         end
      end
   end

   // Address decode on the latched address; lowest matching index wins
   always_comb begin
      dec_hit = 1'b0;
      dec_sel = '0;
      for (int unsigned i = 0; i < N_SLV; i++) begin
         if (!dec_hit && ((addr_q & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
            dec_hit = 1'b1;
            dec_sel = SW'(i);
         end
      end
   end

   // Response fields of the selected slave only
   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      sel_rerr   = 1'b0;
      for (int unsigned i = 0; i < N_SLV; i++) begin
         if (dec_sel == SW'(i)) begin
            sel_rvalid = bus.s_resp_valid[i];
            sel_rdata  = bus.s_resp_rdata[32*i +: 32];
            sel_rerr   = bus.s_resp_err[i];
         end
      end
   end

   // State and transaction latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= XBAR_IDLE;
         last_q   <= MW'(N_MST - 1);
         owner_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         timer_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         decerr_q <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         timer_q  <= timer_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         decerr_q <= decerr_d;
         tmo_q    <= tmo_d;
      end
   end

   // Next state: accept, issue or fail decode, wait with timeout, respond
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      timer_d  = timer_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      decerr_d = decerr_q;
      tmo_d    = tmo_q;
      case (state_q)
         XBAR_IDLE: begin
            if (arb_any) begin
               state_d = XBAR_ISSUE;
               last_d  = arb_idx;
               owner_d = arb_idx;
               we_d    = win_we;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               wstrb_d = win_wstrb;
            end
         end
         XBAR_ISSUE: begin
            if (dec_hit) begin
               state_d = XBAR_WAIT;
               timer_d = '0;
            end else begin
               state_d  = XBAR_RESP;
               rdata_d  = '0;
               err_d    = 1'b1;
               decerr_d = sat_inc16(decerr_q);
            end
         end
         XBAR_WAIT: begin
            if (sel_rvalid) begin
               state_d = XBAR_RESP;
               rdata_d = sel_rdata;
               err_d   = sel_rerr;
            end else if (timer_q == 16'(TIMEOUT - 1)) begin
               state_d = XBAR_RESP;
               rdata_d = '0;
               err_d   = 1'b1;
               tmo_d   = sat_inc16(tmo_q);
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         XBAR_RESP: state_d = XBAR_IDLE;
         default:   state_d = XBAR_IDLE;
      endcase
   end

   // Outputs: single-cycle pulses decoded from the current state
   always_comb begin
      bus.m_req_ready  = '0;
      bus.s_req_valid  = '0;
      bus.m_resp_valid = '0;
      // ready is combinational on the inputs, so hold it low while in reset
      if (state_q == XBAR_IDLE && !rst) begin
         bus.m_req_ready = arb_grant;
      end
      for (int unsigned i = 0; i < N_SLV; i++) begin
         bus.s_req_valid[i] = (state_q == XBAR_ISSUE) && dec_hit && (dec_sel == SW'(i));
      end
      for (int unsigned i = 0; i < N_MST; i++) begin
         bus.m_resp_valid[i] = (state_q == XBAR_RESP) && (owner_q == MW'(i));
      end
   end

   assign bus.s_req_we     = we_q;
   assign bus.s_req_addr   = addr_q;
   assign bus.s_req_wdata  = wdata_q;
   assign bus.s_req_wstrb  = wstrb_q;
   assign bus.m_resp_rdata = rdata_q;
   assign bus.m_resp_err   = err_q;
   assign busy             = (state_q != XBAR_IDLE);
   assign decerr_cnt       = decerr_q;
   assign tmo_cnt          = tmo_q;

endmodule
